ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
- Multi-cycle sequencer that executes ARM block transfers (LDM/STM) against the single-cycle datapath's register file and data memory.
- It is the initiator side of the register-file port. It drives read and write addresses, write enable and write data one register per cycle, walking a 16-bit register list.
- The core control unit raises `start` on a decoded LDM/STM and holds the PC while `busy` is high.

Parameters:
- DATA_W, 32, width of register, address and memory data paths
- WORD_BYTES, 4, address increment per transferred register

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- pre  in  1  P bit: 1 = increment/decrement before transfer
- up  in  1  U bit: 1 = ascending addresses
- wback  in  1  W bit: write updated base to base_reg
- base_reg  in  4  base register index
- reg_list  in  16  register list, bit i = Ri
- base_val  in  DATA_W  current contents of base_reg, sampled at start
- rf_rdata  in  DATA_W  register-file read data for rf_raddr (combinational)
- mem_rdata  in  DATA_W  memory read data for mem_addr (same-cycle)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on completion
- rf_raddr  out  4  register-file read address
- rf_waddr  out  4  register-file write address
- rf_we  out  1  register-file write enable
- rf_wdata  out  DATA_W  register-file write data
- mem_addr  out  DATA_W  data memory word address (byte address, word aligned)
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; every output 0; internal latches cleared.
  - Reset asserted mid-transfer aborts immediately; no further strobes; no done pulse.
- States: IDLE, XFER, WB, DONE.
- IDLE:
  - On start = 1, latch is_load, pre, up, wback, base_reg, reg_list and base_val.
  - Compute N = popcount(reg_list) and the start address:
    - IA (P=0, U=1): base
    - IB (P=1, U=1): base + 4
    - DA (P=0, U=0): base − 4N + 4
    - DB (P=1, U=0): base − 4N
  - Next state: XFER if N > 0, else DONE.
  - start is ignored in all other states.
- XFER, one register per cycle:
  - Selects the lowest set bit of the remaining list and clears it after the cycle.
  - mem_addr = current address; it advances by +4 every cycle regardless of U, so the lowest register always maps to the lowest address.
  - Load cycle: mem_re = 1, rf_waddr = Ri, rf_we = 1, rf_wdata = mem_rdata.
  - Store cycle: mem_we = 1, rf_raddr = Ri, mem_wdata = rf_rdata. R15 reads as PC via the register file.
  - Exactly N XFER cycles.
  - After the last one, go to WB if wback = 1 and not (is_load and reg_list[base_reg]); otherwise go to DONE.
- WB (1 cycle):
  - rf_waddr = base_reg, rf_we = 1.
  - rf_wdata = base + 4N if U = 1, else base − 4N, modulo 2^DATA_W.
  - Then go to DONE.
- DONE (1 cycle): done = 1, then IDLE.
- Total busy cycles = N + (WB ? 1 : 0) + 1.
- Strobes are mutually exclusive by state. mem_re, mem_we and rf_we are never high in IDLE or DONE.
- Outputs not active in a cycle are driven to 0.
- Address arithmetic wraps modulo 2^DATA_W; no alignment check; base_val is taken as given.
- Load base in list: the loaded value wins and writeback is suppressed.
- Store base in list: the original base value is stored, because WB occurs after all XFER cycles.
- Load into R15: rf_waddr = 15 is driven as for any register; PC redirect is the register file's responsibility.
- Empty list (N = 0): no memory access, no writeback; done pulses in the second cycle after start.

Test Plan:
- Reset: rst_n low while in XFER with reg_list = 16'h00FF → outputs 0 immediately, state IDLE, no done pulse; start after release works normally.
- LDM IA with writeback:
  - Stimulus: base_val = 0x100, reg_list = 0x0015, wback = 1, base_reg = 13.
  - Reads 0x100→R0, 0x104→R2, 0x108→R4.
  - WB writes R13 = 0x10C; done on cycle 5; busy for 5 cycles.
- STM DB with writeback:
  - Stimulus: base_val = 0x200, reg_list = 0x4003, base_reg = 13.
  - Writes R0@0x1F4, R1@0x1F8, R14@0x1FC; WB writes R13 = 0x1F4.
- LDM base in list: base_reg = 3, reg_list = 0x0008, wback = 1, mem_rdata = 0xDEADBEEF → R3 = 0xDEADBEEF, no WB cycle, done on cycle 2.
- Empty list, plus start while busy:
  - reg_list = 0 → no strobes, done pulses in the second cycle after start.
  - A second start during a 4-register transfer is ignored; exactly 4 accesses occur.
- Wrap-around: IB, base_val = 0xFFFFFFFC, reg_list = 0x0003, wback = 1 → addresses 0x0, 0x4; WB value 0x4.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list one register per
// cycle between the register file and data memory, with optional base writeback.
module ldm_stm_sequencer #(
  parameter int DATA_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_load,
  input  logic              pre,
  input  logic              up,
  input  logic              wback,
  input  logic [3:0]        base_reg,
  input  logic [15:0]       reg_list,
  input  logic [DATA_W-1:0] base_val,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rf_raddr,
  output logic [3:0]        rf_waddr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

  state_t            state, state_next;
  logic              lat_load;
  logic [3:0]        lat_base;
  logic [15:0]       list_rem;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wb_val;
  logic              wb_en;

  logic [4:0]        n;
  logic [DATA_W-1:0] span;
  logic [DATA_W-1:0] start_addr;
  logic [3:0]        cur_idx;
  logic              last;

  always_comb begin
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + 5'(reg_list[i]);
    span = DATA_W'(n) * STEP;
    case ({pre, up})
      2'b01:   start_addr = base_val;
      2'b11:   start_addr = base_val + STEP;
      2'b00:   start_addr = base_val - span + STEP;
      default: start_addr = base_val - span;
    endcase
  end

  // Lowest set bit wins, so loop downward and let the last hit stick.
  always_comb begin
    cur_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list_rem[i]) cur_idx = 4'(i);
    end
    last = (list_rem & (list_rem - 16'd1)) == 16'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_load <= 1'b0;
      lat_base <= 4'd0;
      list_rem <= 16'd0;
      addr     <= '0;
      wb_val   <= '0;
      wb_en    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            lat_load <= is_load;
            lat_base <= base_reg;
            list_rem <= reg_list;
            addr     <= start_addr;
            // A loaded base overrides writeback.
            wb_en    <= wback & ~(is_load & reg_list[base_reg]);
            wb_val   <= up ? (base_val + span) : (base_val - span);
          end
        end
        XFER: begin
          list_rem <= list_rem & (list_rem - 16'd1);
          addr     <= addr + STEP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    rf_raddr   = 4'd0;
    rf_waddr   = 4'd0;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (start) state_next = (n != 5'd0) ? XFER : DONE;
      end
      XFER: begin
        busy     = 1'b1;
        mem_addr = addr;
        if (lat_load) begin
          mem_re   = 1'b1;
          rf_waddr = cur_idx;
          rf_we    = 1'b1;
          rf_wdata = mem_rdata;
        end else begin
          mem_we    = 1'b1;
          rf_raddr  = cur_idx;
          mem_wdata = rf_rdata;
        end
        if (last) state_next = wb_en ? WB : DONE;
      end
      WB: begin
        busy       = 1'b1;
        rf_waddr   = lat_base;
        rf_we      = 1'b1;
        rf_wdata   = wb_val;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: each cycle of every transfer is checked
// against hand-computed bus values.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_load, pre, up, wback;
  logic [3:0]  base_reg;
  logic [15:0] reg_list;
  logic [31:0] base_val, rf_rdata, mem_rdata;
  logic        busy, done, rf_we, mem_re, mem_we;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_wdata, mem_addr, mem_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Register file model: Ri reads as 0xA000_000i.
  assign rf_rdata = 32'hA000_0000 | {28'd0, rf_raddr};

  ldm_stm_sequencer #(.DATA_W(32), .WORD_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .pre(pre),
    .up(up), .wback(wback), .base_reg(base_reg), .reg_list(reg_list),
    .base_val(base_val), .rf_rdata(rf_rdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input logic eb, input logic ed,
                            input logic [3:0] era, input logic [3:0] ewa, input logic ewe,
                            input logic [31:0] ewd, input logic [31:0] ema, input logic ere,
                            input logic emwe, input logic [31:0] emwd);
    checkOutput({tag, ".busy"},      32'(busy),      32'(eb));
    checkOutput({tag, ".done"},      32'(done),      32'(ed));
    checkOutput({tag, ".rf_raddr"},  32'(rf_raddr),  32'(era));
    checkOutput({tag, ".rf_waddr"},  32'(rf_waddr),  32'(ewa));
    checkOutput({tag, ".rf_we"},     32'(rf_we),     32'(ewe));
    checkOutput({tag, ".rf_wdata"},  rf_wdata,       ewd);
    checkOutput({tag, ".mem_addr"},  mem_addr,       ema);
    checkOutput({tag, ".mem_re"},    32'(mem_re),    32'(ere));
    checkOutput({tag, ".mem_we"},    32'(mem_we),    32'(emwe));
    checkOutput({tag, ".mem_wdata"}, mem_wdata,      emwd);
  endtask

  task automatic checkIdle(input string tag);
    checkCycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Present a one-cycle start; outputs of the following cycle belong to the caller.
  task automatic applyStimulus(input logic il, input logic p, input logic u, input logic w,
                               input logic [3:0] br, input logic [15:0] rl, input logic [31:0] bv);
    @(negedge clk);
    is_load = il; pre = p; up = u; wback = w;
    base_reg = br; reg_list = rl; base_val = bv; start = 1'b1;
  endtask

  // Advance to the next cycle with start low, then let outputs settle.
  task automatic nextCycle(input logic [31:0] rdata);
    @(negedge clk);
    start = 1'b0;
    mem_rdata = rdata;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 0; is_load = 0; pre = 0; up = 0; wback = 0;
    base_reg = 0; reg_list = 0; base_val = 0; mem_rdata = 32'h5555_5555;
    #12;
    checkIdle("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkIdle("after_release");

    // Reset during an STM transfer aborts at once.
    applyStimulus(0, 0, 1, 1, 4'd13, 16'h00FF, 32'h0000_0800);
    nextCycle(32'h5555_5555);
    checkCycle("abort_x0", 1, 0, 0, 0, 0, 0, 32'h800, 0, 1, 32'hA000_0000);
    nextCycle(32'h5555_5555);
    checkCycle("abort_x1", 1, 0, 1, 0, 0, 0, 32'h804, 0, 1, 32'hA000_0001);
    rst_n = 1'b0;
    #1;
    checkIdle("abort_now");
    nextCycle(32'h5555_5555);
    checkIdle("abort_hold");
    rst_n = 1'b1;
    nextCycle(32'h5555_5555);
    checkIdle("abort_after");

    // LDM IA, writeback of R13.
    applyStimulus(1, 0, 1, 1, 4'd13, 16'h0015, 32'h0000_0100);
    nextCycle(32'h1111_1111);
    checkCycle("ia_r0", 1, 0, 0, 0, 1, 32'h1111_1111, 32'h100, 1, 0, 0);
    nextCycle(32'h2222_2222);
    checkCycle("ia_r2", 1, 0, 0, 2, 1, 32'h2222_2222, 32'h104, 1, 0, 0);
    nextCycle(32'h3333_3333);
    checkCycle("ia_r4", 1, 0, 0, 4, 1, 32'h3333_3333, 32'h108, 1, 0, 0);
    nextCycle(32'h5555_5555);
    checkCycle("ia_wb", 1, 0, 0, 13, 1, 32'h10C, 0, 0, 0, 0);
    nextCycle(32'h5555_5555);
    checkCycle("ia_done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(32'h5555_5555);
    checkIdle("ia_idle");

    // STM DB, writeback of R13.
    applyStimulus(0, 1, 0, 1, 4'd13, 16'h4003, 32'h0000_0200);
    nextCycle(32'h5555_5555);
    checkCycle("db_r0", 1, 0, 0, 0, 0, 0, 32'h1F4, 0, 1, 32'hA000_0000);
    nextCycle(32'h5555_5555);
    checkCycle("db_r1", 1, 0, 1, 0, 0, 0, 32'h1F8, 0, 1, 32'hA000_0001);
    nextCycle(32'h5555_5555);
    checkCycle("db_r14", 1, 0, 14, 0, 0, 0, 32'h1FC, 0, 1, 32'hA000_000E);
    nextCycle(32'h5555_5555);
    checkCycle("db_wb", 1, 0, 0, 13, 1, 32'h1F4, 0, 0, 0, 0);
    nextCycle(32'h5555_5555);
    checkCycle("db_done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // LDM with base in list: loaded value wins, no writeback.
    applyStimulus(1, 0, 1, 1, 4'd3, 16'h0008, 32'h0000_0300);
    nextCycle(32'hDEAD_BEEF);
    checkCycle("bil_r3", 1, 0, 0, 3, 1, 32'hDEAD_BEEF, 32'h300, 1, 0, 0);
    nextCycle(32'h5555_5555);
    checkCycle("bil_done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(32'h5555_5555);
    checkIdle("bil_idle");

    // Empty list: straight to DONE.
    applyStimulus(0, 0, 1, 1, 4'd13, 16'h0000, 32'h0000_0700);
    nextCycle(32'h5555_5555);
    checkCycle("empty_done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(32'h5555_5555);
    checkIdle("empty_idle");

    // Second start mid-transfer is ignored.
    applyStimulus(0, 0, 1, 0, 4'd13, 16'h000F, 32'h0000_0400);
    nextCycle(32'h5555_5555);
    checkCycle("sb_r0", 1, 0, 0, 0, 0, 0, 32'h400, 0, 1, 32'hA000_0000);
    @(negedge clk);
    is_load = 1; reg_list = 16'h00F0; base_val = 32'h9000; start = 1'b1;
    #1;
    checkCycle("sb_r1", 1, 0, 1, 0, 0, 0, 32'h404, 0, 1, 32'hA000_0001);
    nextCycle(32'h5555_5555);
    checkCycle("sb_r2", 1, 0, 2, 0, 0, 0, 32'h408, 0, 1, 32'hA000_0002);
    nextCycle(32'h5555_5555);
    checkCycle("sb_r3", 1, 0, 3, 0, 0, 0, 32'h40C, 0, 1, 32'hA000_0003);
    nextCycle(32'h5555_5555);
    checkCycle("sb_done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(32'h5555_5555);
    checkIdle("sb_idle");

    // IB with address wrap-around.
    applyStimulus(1, 1, 1, 1, 4'd5, 16'h0003, 32'hFFFF_FFFC);
    nextCycle(32'h0000_00A0);
    checkCycle("wrap_r0", 1, 0, 0, 0, 1, 32'hA0, 32'h0, 1, 0, 0);
    nextCycle(32'h0000_00A1);
    checkCycle("wrap_r1", 1, 0, 0, 1, 1, 32'hA1, 32'h4, 1, 0, 0);
    nextCycle(32'h5555_5555);
    checkCycle("wrap_wb", 1, 0, 0, 5, 1, 32'h4, 0, 0, 0, 0);
    nextCycle(32'h5555_5555);
    checkCycle("wrap_done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // DA: base - 4N + 4, descending writeback.
    applyStimulus(1, 0, 0, 1, 4'd2, 16'h8001, 32'h0000_0500);
    nextCycle(32'h0000_0B00);
    checkCycle("da_r0", 1, 0, 0, 0, 1, 32'hB00, 32'h4FC, 1, 0, 0);
    nextCycle(32'h0000_0B0F);
    checkCycle("da_r15", 1, 0, 0, 15, 1, 32'hB0F, 32'h500, 1, 0, 0);
    nextCycle(32'h5555_5555);
    checkCycle("da_wb", 1, 0, 0, 2, 1, 32'h4F8, 0, 0, 0, 0);
    nextCycle(32'h5555_5555);
    checkCycle("da_done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(32'h5555_5555);
    checkIdle("da_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
